// File: rtl/md5_pkg.sv
// Shared MD5 constants and the padder state encoding.
package md5_pkg;

    localparam int          MD5_BLOCK_BITS  = 512;
    localparam int          MD5_BLOCK_BYTES = MD5_BLOCK_BITS / 8;
    localparam logic [7:0]  MD5_PAD_BYTE    = 8'h80;
    localparam int          MD5_LEN_OFFSET  = 56;

    localparam logic [1:0]  ST_ABSORB_ENC     = 2'd0;
    localparam logic [1:0]  ST_EMIT_DATA_ENC  = 2'd1;
    localparam logic [1:0]  ST_EMIT_SPILL_ENC = 2'd2;
    localparam logic [1:0]  ST_EMIT_FINAL_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_ABSORB     = ST_ABSORB_ENC,
        ST_EMIT_DATA  = ST_EMIT_DATA_ENC,
        ST_EMIT_SPILL = ST_EMIT_SPILL_ENC,
        ST_EMIT_FINAL = ST_EMIT_FINAL_ENC
    } pad_state_e;

endpackage

// File: rtl/md5_message_padder.sv
// Byte-stream to 512-bit MD5 block padder; single 64-byte buffer, no input/output overlap.
//
// state       | meaning
// ABSORB      | accepting message bytes into the buffer
// EMIT_DATA   | full non-final block offered downstream
// EMIT_SPILL  | padded block without room for the length; extra block follows
// EMIT_FINAL  | last block of the message (carries the bit length)
module md5_message_padder
    import md5_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                in_data,
    input  logic                      in_keep,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [MD5_BLOCK_BITS-1:0] blk_data,
    output logic                      blk_last,
    output logic                      blk_valid,
    input  logic                      blk_ready
);

    pad_state_e  state_q, state_d;
    logic [7:0]  buf_q [MD5_BLOCK_BYTES];
    logic [7:0]  buf_d [MD5_BLOCK_BYTES];
    logic [6:0]  idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic        pad_first_q, pad_first_d;
    logic [6:0]  n_fin;
    logic [63:0] len_field;
    logic        accept;
    logic        blk_hs;

    assign in_ready  = (state_q == ST_ABSORB);
    assign blk_valid = (state_q != ST_ABSORB);
    assign blk_last  = (state_q == ST_EMIT_FINAL);
    assign accept    = in_valid & in_ready;
    assign blk_hs    = blk_valid & blk_ready;

    always_comb begin
        blk_data = '0;
        for (int k = 0; k < MD5_BLOCK_BYTES; k++) begin
            blk_data[8*k +: 8] = buf_q[k];
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        pad_first_d = pad_first_q;
        buf_d       = buf_q;
        n_fin       = idx_q;
        len_field   = '0;

        case (state_q)
            ST_ABSORB: begin
                if (accept) begin
                    if (in_keep) begin
                        buf_d[idx_q[5:0]] = in_data;
                        n_fin             = idx_q + 7'd1;
                        len_d             = len_q + LEN_W'(8);
                    end
                    idx_d = n_fin;
                    if (in_last) begin
                        len_field[LEN_W-1:0] = len_d;
                        pad_first_d          = (n_fin == 7'd64);
                        // Bytes past n_fin are already zero: the buffer is cleared after every block.
                        if (n_fin < 7'd64) begin
                            buf_d[n_fin[5:0]] = MD5_PAD_BYTE;
                        end
                        if (n_fin <= 7'(MD5_LEN_OFFSET - 1)) begin
                            for (int j = 0; j < 8; j++) begin
                                buf_d[MD5_LEN_OFFSET + j] = len_field[8*j +: 8];
                            end
                            state_d = ST_EMIT_FINAL;
                        end else begin
                            state_d = ST_EMIT_SPILL;
                        end
                    end else if (n_fin == 7'd64) begin
                        state_d = ST_EMIT_DATA;
                    end
                end
            end
            ST_EMIT_DATA: begin
                if (blk_hs) begin
                    for (int k = 0; k < MD5_BLOCK_BYTES; k++) buf_d[k] = '0;
                    idx_d   = '0;
                    state_d = ST_ABSORB;
                end
            end
            ST_EMIT_SPILL: begin
                if (blk_hs) begin
                    len_field[LEN_W-1:0] = len_q;
                    for (int k = 0; k < MD5_BLOCK_BYTES; k++) buf_d[k] = '0;
                    buf_d[0] = pad_first_q ? MD5_PAD_BYTE : 8'h00;
                    for (int j = 0; j < 8; j++) begin
                        buf_d[MD5_LEN_OFFSET + j] = len_field[8*j +: 8];
                    end
                    state_d = ST_EMIT_FINAL;
                end
            end
            ST_EMIT_FINAL: begin
                if (blk_hs) begin
                    for (int k = 0; k < MD5_BLOCK_BYTES; k++) buf_d[k] = '0;
                    idx_d       = '0;
                    len_d       = '0;
                    pad_first_d = 1'b0;
                    state_d     = ST_ABSORB;
                end
            end
            default: state_d = ST_ABSORB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ABSORB;
            idx_q       <= '0;
            len_q       <= '0;
            pad_first_q <= 1'b0;
            for (int k = 0; k < MD5_BLOCK_BYTES; k++) buf_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            pad_first_q <= pad_first_d;
            for (int k = 0; k < MD5_BLOCK_BYTES; k++) buf_q[k] <= buf_d[k];
        end
    end

endmodule

// File: tb/tb_md5_message_padder.sv
// Directed bench for md5_message_padder: hand-computed words plus a textbook MD5 padding model.
module tb_md5_message_padder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_keep = 1'b0;
    logic         in_last = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         blk_valid;
    logic         blk_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0]   cur_msg [$];
    logic [511:0] exp_blk [$];
    logic [511:0] rx_blk  [$];
    logic         rx_last [$];

    always #5 clk = ~clk;

    md5_message_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Standard MD5 padding of cur_msg into 512-bit little-endian blocks.
    task automatic build_expected();
        logic [7:0]   p [$];
        logic [63:0]  bits;
        logic [511:0] blk;
        p    = cur_msg;
        bits = 64'(cur_msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int j = 0; j < 8; j++) p.push_back(bits[8*j +: 8]);
        exp_blk.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int k = 0; k < 64; k++) blk[8*k +: 8] = p[64*b + k];
            exp_blk.push_back(blk);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
        int t = 0;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_keep  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input bit clean_end);
        int n = cur_msg.size();
        if (clean_end) send_beat(8'hff, 1'b0, 1'b0);
        if (n == 0) begin
            send_beat(8'h00, 1'b0, 1'b1);
        end else begin
            for (int i = 0; i < n; i++) begin
                send_beat(cur_msg[i], 1'b1, (i == n - 1) && !clean_end);
                if (clean_end && i == 0) send_beat(8'hee, 1'b0, 1'b0);
            end
            if (clean_end) send_beat(8'h00, 1'b0, 1'b1);
        end
    endtask

    task automatic recv_blocks(input int nblk, input int stall);
        logic [511:0] d;
        logic         l;
        int           t;
        rx_blk.delete();
        rx_last.delete();
        for (int b = 0; b < nblk; b++) begin
            t = 0;
            @(negedge clk);
            while (!blk_valid && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 2000) begin
                check("recv_timeout", 1, 0);
                break;
            end
            d = blk_data;
            l = blk_last;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("stall_valid", 512'(blk_valid), 1);
                check("stall_data", blk_data, d);
                check("stall_last", 512'(blk_last), 512'(l));
                check("stall_in_ready", 512'(in_ready), 0);
            end
            blk_ready = 1'b1;
            @(posedge clk);
            #1;
            blk_ready = 1'b0;
            rx_blk.push_back(d);
            rx_last.push_back(l);
        end
    endtask

    task automatic run_msg(input string tag, input int stall, input bit clean_end);
        build_expected();
        fork
            send_msg(clean_end);
            recv_blocks(exp_blk.size(), stall);
        join
        check({tag, "_nblk"}, 512'(rx_blk.size()), 512'(exp_blk.size()));
        for (int b = 0; b < rx_blk.size() && b < exp_blk.size(); b++) begin
            check($sformatf("%s_blk%0d", tag, b), rx_blk[b], exp_blk[b]);
            check($sformatf("%s_last%0d", tag, b), 512'(rx_last[b]), 512'(b == exp_blk.size() - 1));
        end
    endtask

    function automatic logic [31:0] rx_word(input int b, input int w);
        logic [511:0] blk;
        blk = (b < rx_blk.size()) ? rx_blk[b] : '0;
        return blk[32*w +: 32];
    endfunction

    initial begin
        string s;

        #12;
        check("rst_valid", 512'(blk_valid), 0);
        check("rst_last", 512'(blk_last), 0);
        check("rst_data", blk_data, 0);
        check("rst_in_ready", 512'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: 55-byte message, padding and length fit in one block
        s = "Hello ENPM808! This is my MD5 implementation in verilog";
        cur_msg.delete();
        for (int i = 0; i < s.len(); i++) cur_msg.push_back(s[i]);
        run_msg("t1", 0, 1'b0);
        check("t1_w0",  512'(rx_word(0, 0)),  512'(32'h6c6c6548));
        check("t1_w12", 512'(rx_word(0, 12)), 512'(32'h69726576));
        check("t1_w13", 512'(rx_word(0, 13)), 512'(32'h80676f6c));
        check("t1_w14", 512'(rx_word(0, 14)), 512'(32'h000001b8));
        check("t1_w15", 512'(rx_word(0, 15)), 512'(32'h00000000));

        // 2: empty message
        cur_msg.delete();
        run_msg("t2", 0, 1'b0);
        check("t2_blk", (rx_blk.size() > 0) ? rx_blk[0] : '1, 512'h80);

        // 3: 56 bytes, pad byte lands in 56 and length spills
        cur_msg.delete();
        for (int i = 0; i < 56; i++) cur_msg.push_back(8'h61);
        run_msg("t3", 0, 1'b0);
        check("t3_a_w13", 512'(rx_word(0, 13)), 512'(32'h61616161));
        check("t3_a_w14", 512'(rx_word(0, 14)), 512'(32'h00000080));
        check("t3_b_w0",  512'(rx_word(1, 0)),  512'(32'h00000000));
        check("t3_b_w14", 512'(rx_word(1, 14)), 512'(32'h000001c0));

        // 4: exactly 64 bytes, pad byte opens the extra block
        cur_msg.delete();
        for (int i = 0; i < 64; i++) cur_msg.push_back(8'h00);
        run_msg("t4", 0, 1'b0);
        check("t4_a", (rx_blk.size() > 0) ? rx_blk[0] : '1, 0);
        check("t4_b_w0",  512'(rx_word(1, 0)),  512'(32'h00000080));
        check("t4_b_w14", 512'(rx_word(1, 14)), 512'(32'h00000200));

        // 5: 130 bytes with 5-cycle stalls on each block
        cur_msg.delete();
        for (int i = 0; i < 130; i++) cur_msg.push_back(8'(i * 7 + 3));
        run_msg("t5", 5, 1'b0);
        check("t5_w14", 512'(rx_word(2, 14)), 512'(32'h00000410));

        // 7: dropped keep=0 beats and a clean end beat do not count
        cur_msg.delete();
        cur_msg.push_back(8'h61); cur_msg.push_back(8'h62); cur_msg.push_back(8'h63);
        run_msg("t7", 1, 1'b1);
        check("t7_w0",  512'(rx_word(0, 0)),  512'(32'h80636261));
        check("t7_w14", 512'(rx_word(0, 14)), 512'(32'h00000018));

        // 6: reset while a full block is waiting
        for (int i = 0; i < 64; i++) send_beat(8'h5a, 1'b1, 1'b0);
        @(negedge clk);
        check("t6_pre_valid", 512'(blk_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 512'(blk_valid), 0);
        check("t6_rst_data", blk_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cur_msg.delete();
        cur_msg.push_back(8'h61); cur_msg.push_back(8'h62); cur_msg.push_back(8'h63);
        run_msg("t6", 0, 1'b0);
        check("t6_w0",  512'(rx_word(0, 0)),  512'(32'h80636261));
        check("t6_w14", 512'(rx_word(0, 14)), 512'(32'h00000018));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
